// File: rtl/addsub_pkg.sv
// Shared op-code and saturation-mode encodings for the add/subtract accumulator unit.
package addsub_pkg;

    typedef enum logic [2:0] {
        OP_ADD     = 3'd0,
        OP_SUB     = 3'd1,
        OP_ACC_ADD = 3'd2,
        OP_ACC_SUB = 3'd3,
        OP_LOAD    = 3'd4
    } op_e;

    localparam int unsigned SAT_WRAP     = 0;
    localparam int unsigned SAT_UNSIGNED = 1;
    localparam int unsigned SAT_SIGNED   = 2;

endpackage

// File: rtl/nbit_addsub_core.sv
// Combinational WIDTH-bit ripple-carry adder/subtractor (subtract = x + ~y + 1).
module nbit_addsub_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] w_y;
    logic [WIDTH:0]   w_c;

    always_comb begin
        w_y    = y ^ {WIDTH{sub}};
        w_c    = '0;
        sum    = '0;
        w_c[0] = sub;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum[i]   = x[i] ^ w_y[i] ^ w_c[i];
            w_c[i+1] = (x[i] & w_y[i]) | (w_c[i] & (x[i] ^ w_y[i]));
        end
    end

    assign cout = w_c[WIDTH];
    // Signed overflow: carry into the MSB differs from carry out of it.
    assign ovf  = w_c[WIDTH] ^ w_c[WIDTH-1];

endmodule

// File: rtl/addsub_accum_unit.sv
// Registered add/subtract unit with accumulator, optional saturation, status flags
// and valid/ready handshakes; one result per accepted op, one cycle after accept.
module addsub_accum_unit
    import addsub_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      SAT_MODE  = 0,
    parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             sat,
    output logic             zero,
    output logic [WIDTH-1:0] acc
);

    logic [WIDTH-1:0] r_s;
    logic             r_valid;
    logic             r_cout;
    logic             r_ovf;
    logic             r_sat;
    logic             r_zero;
    logic [WIDTH-1:0] r_acc;

    op_e              w_op;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_sub;
    logic [WIDTH-1:0] w_raw;
    logic             w_cout;
    logic             w_ovf;
    logic [WIDTH-1:0] w_clamped;
    logic             w_clamp_hit;
    logic [WIDTH-1:0] w_res;
    logic             w_res_cout;
    logic             w_res_ovf;
    logic             w_res_sat;
    logic             w_res_zero;
    logic             w_acc_wr;
    logic             w_accept;

    assign w_op = op_e'(op);

    always_comb begin
        w_x   = a;
        w_y   = b;
        w_sub = 1'b0;
        case (w_op)
            OP_SUB:     w_sub = 1'b1;
            OP_ACC_ADD: begin w_x = r_acc; w_y = a; end
            OP_ACC_SUB: begin w_x = r_acc; w_y = a; w_sub = 1'b1; end
            default:    ;
        endcase
    end

    nbit_addsub_core #(.WIDTH(WIDTH)) u_core (
        .x    (w_x),
        .y    (w_y),
        .sub  (w_sub),
        .sum  (w_raw),
        .cout (w_cout),
        .ovf  (w_ovf)
    );

    always_comb begin
        w_clamped   = w_raw;
        w_clamp_hit = 1'b0;
        if (SAT_MODE == SAT_UNSIGNED) begin
            if (!w_sub && w_cout) begin
                w_clamped   = '1;
                w_clamp_hit = 1'b1;
            end else if (w_sub && !w_cout) begin
                w_clamped   = '0;
                w_clamp_hit = 1'b1;
            end
        end else if (SAT_MODE == SAT_SIGNED && w_ovf) begin
            // Clamp toward the sign of the first operand.
            w_clamped   = w_x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            w_clamp_hit = 1'b1;
        end
    end

    always_comb begin
        w_res      = r_acc;
        w_res_cout = 1'b0;
        w_res_ovf  = 1'b0;
        w_res_sat  = 1'b0;
        w_res_zero = 1'b0;
        w_acc_wr   = 1'b0;
        case (w_op)
            OP_ADD, OP_SUB, OP_ACC_ADD, OP_ACC_SUB: begin
                w_res      = w_clamped;
                w_res_cout = w_cout;
                w_res_ovf  = w_ovf;
                w_res_sat  = w_clamp_hit;
                w_res_zero = (w_clamped == '0);
                w_acc_wr   = (w_op == OP_ACC_ADD) || (w_op == OP_ACC_SUB);
            end
            OP_LOAD: begin
                w_res      = a;
                w_res_zero = (a == '0);
                w_acc_wr   = 1'b1;
            end
            default: ;
        endcase
    end

    assign in_ready = !rst && enable && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_sat   <= 1'b0;
            r_zero  <= 1'b0;
            r_acc   <= ACC_RESET;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_s     <= w_res;
            r_cout  <= w_res_cout;
            r_ovf   <= w_res_ovf;
            r_sat   <= w_res_sat;
            r_zero  <= w_res_zero;
            if (w_acc_wr) begin
                r_acc <= w_res;
            end
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign s         = r_valid ? r_s : '0;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign sat       = r_sat;
    assign zero      = r_zero;
    assign acc       = r_acc;

endmodule

// File: tb/tb_addsub_accum_unit.sv
// Directed bench: three instances (wrap / unsigned sat / signed sat) share stimulus.
module tb_addsub_accum_unit;
    import addsub_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       in_valid;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_ready;

    logic       in_ready  [3];
    logic       out_valid [3];
    logic [7:0] s         [3];
    logic       cout      [3];
    logic       ovf       [3];
    logic       sat       [3];
    logic       zero      [3];
    logic [7:0] acc       [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        addsub_accum_unit #(
            .WIDTH     (8),
            .SAT_MODE  (g),
            .ACC_RESET ((g == 0) ? 8'hA5 : (g == 1) ? 8'h00 : 8'h10)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .enable    (enable),
            .in_valid  (in_valid),
            .in_ready  (in_ready[g]),
            .op        (op),
            .a         (a),
            .b         (b),
            .out_valid (out_valid[g]),
            .out_ready (out_ready),
            .s         (s[g]),
            .cout      (cout[g]),
            .ovf       (ovf[g]),
            .sat       (sat[g]),
            .zero      (zero[g]),
            .acc       (acc[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] aa,
                         input logic [7:0] bb, input logic rdy);
        in_valid  = v;
        op        = o;
        a         = aa;
        b         = bb;
        out_ready = rdy;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        drive(1'b1, OP_LOAD, 8'h77, 8'h00, 1'b1);
        #1;
        chk("rst_in_ready", in_ready[0], 0);
        cyc();
        cyc();
        chk("rst_out_valid", out_valid[0], 0);
        chk("rst_s", s[0], 0);
        chk("rst_flags", {cout[0], ovf[0], sat[0], zero[0]}, 0);
        chk("rst_acc0", acc[0], 8'hA5);
        chk("rst_acc2", acc[2], 8'h10);

        rst = 1'b0;
        drive(1'b0, OP_ADD, 8'h00, 8'h00, 1'b1);
        #1;
        chk("idle_in_ready", in_ready[0], 1);

        // Plain ADD with wrap
        drive(1'b1, OP_ADD, 8'd200, 8'd100, 1'b1);
        cyc();
        chk("add_valid", out_valid[0], 1);
        chk("add_s", s[0], 8'd44);
        chk("add_cout", cout[0], 1);
        chk("add_ovf", ovf[0], 0);
        chk("add_acc_untouched", acc[0], 8'hA5);

        // SUB 0x80 - 0x01
        drive(1'b1, OP_SUB, 8'h80, 8'h01, 1'b1);
        cyc();
        chk("sub_wrap_s", s[0], 8'h7F);
        chk("sub_wrap_ovf_cout", {ovf[0], cout[0], sat[0]}, 3'b110);
        chk("sub_ssat_s", s[2], 8'h80);
        chk("sub_ssat_sat", {ovf[2], sat[2]}, 2'b11);

        // ADD 0x7F + 0x01
        drive(1'b1, OP_ADD, 8'h7F, 8'h01, 1'b1);
        cyc();
        chk("add_ssat_s", s[2], 8'h7F);
        chk("add_ssat_sat", sat[2], 1);
        chk("add_wrap_s", s[0], 8'h80);
        chk("add_usat_nosat", {s[1], sat[1]}, {8'h80, 1'b0});

        // LOAD 0 then three ACC_ADD 0x80
        drive(1'b1, OP_LOAD, 8'h00, 8'h5A, 1'b1);
        cyc();
        chk("load_s_zero", {s[1], zero[1], cout[1], ovf[1], sat[1]}, {8'h00, 4'b1000});
        chk("load_acc", acc[1], 8'h00);
        drive(1'b1, OP_ACC_ADD, 8'h80, 8'h00, 1'b1);
        cyc();
        chk("acc1_usat_s", {s[1], sat[1]}, {8'h80, 1'b0});
        cyc();
        chk("acc2_usat_s", {s[1], sat[1]}, {8'hFF, 1'b1});
        chk("acc2_wrap_s", {s[0], cout[0], zero[0]}, {8'h00, 2'b11});
        chk("acc2_ssat_s", {s[2], sat[2]}, {8'h80, 1'b1});
        cyc();
        chk("acc3_usat_s", {s[1], sat[1]}, {8'hFF, 1'b1});
        chk("acc3_usat_acc", acc[1], 8'hFF);
        chk("acc3_wrap_acc", acc[0], 8'h80);

        // ACC_SUB 0x10
        drive(1'b1, OP_ACC_SUB, 8'h10, 8'h00, 1'b1);
        cyc();
        chk("accsub_usat", {s[1], cout[1], sat[1]}, {8'hEF, 2'b10});
        chk("accsub_wrap", {s[0], ovf[0]}, {8'h70, 1'b1});
        chk("accsub_ssat", {s[2], sat[2]}, {8'h80, 1'b1});

        // NOP returns acc
        drive(1'b1, 3'd5, 8'h33, 8'h44, 1'b1);
        cyc();
        chk("nop_s", s[1], 8'hEF);
        chk("nop_flags", {cout[1], ovf[1], sat[1], zero[1]}, 0);
        chk("nop_acc", acc[1], 8'hEF);

        // Backpressure for three cycles
        drive(1'b1, OP_ADD, 8'd1, 8'd2, 1'b0);
        #1;
        chk("bp_in_ready", in_ready[1], 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_hold_s", s[1], 8'hEF);
            chk("bp_hold_acc", acc[1], 8'hEF);
            chk("bp_hold_valid", out_valid[1], 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready[1], 1);
        cyc();
        chk("b2b_1", s[0], 8'd3);
        drive(1'b1, OP_ADD, 8'd3, 8'd4, 1'b1);
        cyc();
        chk("b2b_2", {out_valid[0], s[0]}, {1'b1, 8'd7});

        // Reset mid-stream
        drive(1'b1, OP_LOAD, 8'h35, 8'h00, 1'b1);
        cyc();
        chk("pre_rst_acc", acc[0], 8'h35);
        rst = 1'b1;
        drive(1'b1, OP_LOAD, 8'h99, 8'h00, 1'b0);
        cyc();
        chk("mid_rst_valid", out_valid[0], 0);
        chk("mid_rst_s", s[0], 0);
        chk("mid_rst_acc", acc[0], 8'hA5);
        rst = 1'b0;
        drive(1'b0, OP_ADD, 8'h00, 8'h00, 1'b1);
        cyc();

        // enable low: no accept, pending result still consumed
        drive(1'b1, OP_ADD, 8'd9, 8'd1, 1'b0);
        cyc();
        chk("pend_s", s[0], 8'd10);
        enable = 1'b0;
        drive(1'b1, OP_SUB, 8'd5, 8'd5, 1'b0);
        #1;
        chk("dis_in_ready", in_ready[0], 0);
        cyc();
        chk("dis_hold", {out_valid[0], s[0]}, {1'b1, 8'd10});
        out_ready = 1'b1;
        cyc();
        chk("dis_consume", {out_valid[0], s[0]}, {1'b0, 8'd0});
        enable = 1'b1;
        cyc();
        chk("sub_eq_s", {out_valid[0], s[0]}, {1'b1, 8'd0});
        chk("sub_eq_flags", {zero[0], cout[0], ovf[0]}, 3'b110);
        drive(1'b0, OP_ADD, 8'h00, 8'h00, 1'b1);
        cyc();
        chk("drain_valid", out_valid[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/addsub_accum_unit.md
# addsub_accum_unit

Parametrised, registered N-bit adder/subtractor with an internal accumulator, optional saturation, status flags and valid/ready handshakes on input and output. Successor to the fixed 8-bit gated adder/subtractor. Sits in the cruise-control datapath, where it computes speed error (setpoint − measured) and integrates it for the controller. One result is produced per accepted operation, one cycle after acceptance.

## Interface
- WIDTH, 8: operand, accumulator and result width; must be ≥ 2.
- SAT_MODE, 0: saturation mode. 0 = wrap; 1 = unsigned saturate; 2 = signed saturate.
- ACC_RESET, 0: accumulator value after reset, WIDTH bits.

- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- enable  in  1  when low, no operation is accepted (in_ready = 0); registered output and accumulator hold.
- in_valid  in  1  operation present.
- in_ready  out  1  unit can accept this cycle.
- op  in  3  operation code (see Operation).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; ignored by accumulator ops.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  consumer takes the result.
- s  out  WIDTH  result; forced to 0 whenever out_valid = 0.
- cout  out  1  raw carry out; for subtraction, 1 = no borrow.
- ovf  out  1  raw signed overflow.
- sat  out  1  result was clamped (always 0 when SAT_MODE = 0).
- zero  out  1  final s == 0.
- acc  out  WIDTH  current accumulator value.

## Operation
- Op codes:
  - ADD = 0: a + b.
  - SUB = 1: a − b, computed as a + ~b + 1.
  - ACC_ADD = 2: acc + a.
  - ACC_SUB = 3: acc − a.
  - LOAD = 4: result = a, and acc ← a.
  - 5–7: NOP. Result = acc, all flags 0, accumulator unchanged.
- Accept = in_valid & in_ready.
- in_ready = enable & (!out_valid | out_ready).
- On accept:
  - Result and flags are registered.
  - out_valid ← 1.
  - For ACC_ADD, ACC_SUB and LOAD, acc ← final (post-saturation) result.
- ADD and SUB do not touch acc.
- Output consumed (out_valid & out_ready) with no accept in the same cycle: out_valid ← 0.
- Consume and accept in the same cycle: the new result replaces the old; out_valid stays 1. This gives full throughput.
- Saturation:
  - SAT_MODE 1: add with carry clamps to all ones; subtract with borrow clamps to 0.
  - SAT_MODE 2: on ovf, clamp to the signed max (0111…) if the first operand is non-negative, otherwise to the signed min (1000…).
  - sat = 1 whenever a clamp is applied.
- Flags:
  - cout and ovf are taken from the unclamped sum.
  - zero is taken from the final result.
  - LOAD drives cout = ovf = sat = 0 and sets zero normally.
- enable low while out_valid = 1: the result stays presented and may still be consumed.

## Timing
- Latency is 1 cycle. A result accepted on edge N is visible after edge N with out_valid = 1.
- Throughput is 1 operation per cycle while out_ready = 1 and enable = 1.
- Reset values: out_valid = 0, s = 0, cout = ovf = sat = 0, zero = 0, acc = ACC_RESET, in_ready = 0 during the reset cycle.
- rst asserted mid-operation discards any pending result and any accept in the same cycle.
- Accumulator wrap: with SAT_MODE 0 the accumulator wraps modulo 2^WIDTH with no sticky state.
- Consecutive accumulator ops read the acc value as updated by the previous accepted op. There is no hazard, because acc updates on the accept edge.

## Structure
- Shared package addsub_pkg holds:
  - the op-code constants (3-bit localparams or enum);
  - the SAT_MODE encodings.
- Sub-module nbit_addsub_core: combinational WIDTH-bit ripple add/subtract.
  - Inputs: x, y, sub.
  - Outputs: sum, cout, ovf.
- The top level adds operand muxing, saturation, the result/flag register, the accumulator and the handshake.

## Test plan
- WIDTH=8, SAT_MODE=0: ADD a=200, b=100 → s=44, cout=1, ovf=0, one cycle after accept.
- SAT_MODE=2: SUB a=0x80, b=0x01 → raw 0x7F with ovf=1; s=0x80, sat=1. ADD 0x7F + 0x01 → s=0x7F, sat=1.
- SAT_MODE=1: ACC_ADD with a=0x80, three accepts after LOAD 0x00 → s=0x80, then 0xFF (sat=1), then 0xFF (sat=1); acc=0xFF.
- Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, s stable, acc unchanged. Release → back-to-back results at 1 per cycle.
- Assert rst mid-stream with out_valid=1 and acc=0x35 → next cycle out_valid=0, s=0, acc=ACC_RESET.
- enable=0 with in_valid=1 → no accept. Pending result still consumed. SUB a=5, b=5 afterwards → s=0, zero=1, cout=1.
